fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single write side of the asynchronous FIFO (`winc`/`wdata`/`wfull`) among `NREQ` requesters in the write clock domain. It holds a grant for a burst of up to `MAX_BURST` words, stalls on `wfull` without losing data, and rotates fairly among requesters. It sits directly in front of the FIFO's write-pointer/full logic.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `DSIZE`, 8: data word width; matches FIFO `DSIZE`.
- `MAX_BURST`, 4: maximum words accepted per grant, ≥1. The burst counter is `$clog2(MAX_BURST+1)` bits.
- `clk` input 1: single clock; the FIFO write clock.
- `rst` input 1: synchronous, active-high reset.
- `req` input NREQ: per-requester valid; the word is presented on its `req_data` slice.
- `req_data` input NREQ*DSIZE: flattened data; requester i occupies bits `[i*DSIZE +: DSIZE]`.
- `req_ack` output NREQ: one-hot pulse; requester i's word is accepted this cycle.
- `grant` output NREQ: registered one-hot current owner; all zero when idle.
- `wfull` input 1: FIFO full flag.
- `winc` output 1: FIFO write enable.
- `wdata` output DSIZE: FIFO write data.
- `busy` output 1: high while in BURST state.

## Operation
- FSM has two states: IDLE and BURST. Registers are `state`, `grant`, `last` (index of the last owner), and `bcnt`.
- IDLE:
  - If `req` is all zero, remain in IDLE.
  - Otherwise, select the first requester with `req` high, scanning circularly from `last+1`.
  - Load `grant` one-hot, clear `bcnt`, and go to BURST.
  - No beat is accepted in IDLE.
- BURST, owner g:
  - A beat is accepted when `req[g] & ~wfull`. Then `winc=1`, `wdata=req_data[g]`, `req_ack[g]=1`, and `bcnt` increments.
  - `wfull` high: stall. No ack, `bcnt` unchanged, grant held. A stall never counts as release.
  - Release when `req[g]` is low in any cycle, including during a stall.
  - Release when a beat is accepted with `bcnt == MAX_BURST-1`.
  - On release: `last <= g`, `grant <= 0`, go to IDLE.
- Combinational outputs:
  - `winc = busy & req[g] & ~wfull & ~rst`.
  - `wdata` = selected slice when `winc` is high, otherwise 0.
  - `req_ack = grant & {NREQ{winc}}`.
- Non-owners are never acked. Their `req` may stay high indefinitely and must hold data stable until acked.
- Reset values:
  - `state` = IDLE, `grant` = 0, `last` = NREQ-1 (so requester 0 wins first), `bcnt` = 0.
  - `busy`, `winc`, `req_ack` = 0; `wdata` = 0.
- Reset asserted mid-burst:
  - `winc` is forced 0 during the reset cycle, so no beat is written.
  - Grant is cleared at the next edge.
  - The partially sent burst is abandoned; the requester re-requests.

## Timing
- Arbitration latency: `req` seen in IDLE at edge N → `grant` valid after edge N. The first beat is possible in cycle N+1.
- Steady-state throughput: 1 word/cycle within a burst.
- One dead IDLE cycle between consecutive grants. Peak sustained rate is `MAX_BURST/(MAX_BURST+1)`.
- `wfull` is sampled combinationally in the same cycle as `winc`. A word is never presented while `wfull` is high.
- Fairness: with all requesters continuously requesting, each receives exactly one grant per NREQ grants.

## Configuration
- Macro: `FIFO_ARB_BURST_EN`.
- Defined: bursts of up to `MAX_BURST` words, as described above.
- Undefined: `MAX_BURST` is treated as 1.
  - Every accepted beat releases the grant and re-arbitrates.
  - `bcnt` logic is removed.
  - Per-word round-robin at a peak rate of 1 word per 2 cycles.

## Test plan
- Reset, then `req=4'b0000` for 10 cycles → `grant=0`, `winc=0`, `busy=0` throughout. `rst` high for 1 cycle mid-burst → `winc=0` that cycle, `grant=0` after the edge.
- `req=4'b1111` continuous, data `0xA0+i`, `wfull=0`, `MAX_BURST=4`, macro defined → grants in order 0,1,2,3,0. Each grant yields 4 acks. `wdata` sequence is A0×4, A1×4, A2×4, A3×4 with one idle cycle between bursts.
- Requester 2 alone, `wfull` raised after 2 beats for 3 cycles, then dropped → exactly 4 `winc` pulses total. No `winc` or ack while `wfull` high. Grant held through the stall.
- Requester 1 owns the grant and drops `req` after 1 beat while requester 3 is requesting → release after 1 beat; grant moves to 3 after one IDLE cycle.
- Macro undefined, `req=4'b0101` → grant alternates 0,2,0,2 with one ack per grant and `winc` every other cycle.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NREQ requesters.
// Define FIFO_ARB_BURST_EN to hold a grant for up to MAX_BURST words; otherwise every word re-arbitrates.
module fifo_wr_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned DSIZE     = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*DSIZE-1:0] req_data,
    output logic [NREQ-1:0]       req_ack,
    output logic [NREQ-1:0]       grant,
    input  logic                  wfull,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata,
    output logic                  busy
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [NREQ-1:0] grant_nxt;
    logic [IW-1:0]   last, last_nxt;
    logic [IW-1:0]   gidx;
    logic [IW-1:0]   pick;
    logic            found;
    logic            sel_req;
    logic [DSIZE-1:0] sel_data;
    logic            beat_last;

`ifdef FIFO_ARB_BURST_EN
    localparam int unsigned BW = $clog2(MAX_BURST + 1);
    logic [BW-1:0]   bcnt, bcnt_nxt;
`else
    // with bursts disabled every burst is exactly one word long
    localparam int unsigned BURST_LEN = (MAX_BURST >= 1) ? 1 : 0;
`endif

    // owner index decoded from the registered one-hot grant
    always_comb begin
        gidx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) gidx = IW'(i);
        end
        sel_req  = req[gidx];
        sel_data = req_data[gidx*DSIZE +: DSIZE];
    end

    always_comb begin
        busy    = (state == BURST);
        winc    = busy & sel_req & ~wfull & ~rst;
        wdata   = winc ? sel_data : '0;
        req_ack = grant & {NREQ{winc}};
    end

    // circular scan starting just after the previous owner
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            if (!found && req[(32'(last) + k) % NREQ]) begin
                found = 1'b1;
                pick  = IW'((32'(last) + k) % NREQ);
            end
        end
    end

`ifdef FIFO_ARB_BURST_EN
    assign beat_last = (bcnt == BW'(MAX_BURST - 1));
`else
    assign beat_last = (BURST_LEN == 1);
`endif

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        last_nxt  = last;
`ifdef FIFO_ARB_BURST_EN
        bcnt_nxt  = bcnt;
`endif
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = BURST;
                    grant_nxt = NREQ'(1) << pick;
`ifdef FIFO_ARB_BURST_EN
                    bcnt_nxt  = '0;
`endif
                end
            end
            BURST: begin
                // a wfull stall keeps the grant; only a dropped req or the final beat releases
                if (!sel_req || (winc && beat_last)) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                    last_nxt  = gidx;
                end
`ifdef FIFO_ARB_BURST_EN
                else if (winc) begin
                    bcnt_nxt = bcnt + BW'(1);
                end
`endif
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            last  <= IW'(NREQ - 1);
`ifdef FIFO_ARB_BURST_EN
            bcnt  <= '0;
`endif
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            last  <= last_nxt;
`ifdef FIFO_ARB_BURST_EN
            bcnt  <= bcnt_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter; expectations follow FIFO_ARB_BURST_EN (burst of 4 or 1 word).
module tb_fifo_wr_arbiter;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned DSIZE = 8;
`ifdef FIFO_ARB_BURST_EN
    localparam int unsigned BL = 4;
`else
    localparam int unsigned BL = 1;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_ack;
    logic [NREQ-1:0]       grant;
    logic                  wfull;
    logic                  winc;
    logic [DSIZE-1:0]      wdata;
    logic                  busy;

    int n_chk  = 0;
    int n_fail = 0;

    fifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .MAX_BURST(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .req_ack  (req_ack),
        .grant    (grant),
        .wfull    (wfull),
        .winc     (winc),
        .wdata    (wdata),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // drive one cycle of stimulus, check outputs mid-cycle, advance past the next edge
    task automatic cyc(input string tag, input logic [3:0] r, input logic f,
                       input logic [3:0] eg, input logic ew);
        logic [7:0] ed;
        req   = r;
        wfull = f;
        ed    = 8'h00;
        for (int i = 0; i < 4; i++) begin
            if (eg[i]) ed = 8'hA0 + 8'(i);
        end
        @(negedge clk);
        chk({tag, ".grant"}, 32'(grant), 32'(eg));
        chk({tag, ".winc"}, 32'(winc), 32'(ew));
        chk({tag, ".wdata"}, 32'(wdata), ew ? 32'(ed) : 32'h0);
        chk({tag, ".ack"}, 32'(req_ack), ew ? 32'(eg) : 32'h0);
        chk({tag, ".busy"}, 32'(busy), 32'(|eg));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned order4[5];
        int unsigned order2[4];
        order4 = '{0, 1, 2, 3, 0};
        order2 = '{0, 2, 0, 2};
        rst      = 1'b1;
        req      = '0;
        wfull    = 1'b0;
        req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // idle with no requests
        for (int i = 0; i < 10; i++) cyc("idle", 4'b0000, 1'b0, 4'b0000, 1'b0);

        // all requesting: rotation 0,1,2,3,0 with a dead cycle between grants
        for (int o = 0; o < 5; o++) begin
            cyc("rr_gap", 4'b1111, 1'b0, 4'b0000, 1'b0);
            for (int unsigned b = 0; b < BL; b++)
                cyc("rr_beat", 4'b1111, 1'b0, 4'(1 << order4[o]), 1'b1);
        end

        // requester 2 alone with a 3-cycle wfull stall
`ifdef FIFO_ARB_BURST_EN
        cyc("st_gap", 4'b0100, 1'b0, 4'b0000, 1'b0);
        cyc("st_b0",  4'b0100, 1'b0, 4'b0100, 1'b1);
        cyc("st_b1",  4'b0100, 1'b0, 4'b0100, 1'b1);
        for (int i = 0; i < 3; i++) cyc("st_full", 4'b0100, 1'b1, 4'b0100, 1'b0);
        cyc("st_b2",  4'b0100, 1'b0, 4'b0100, 1'b1);
        cyc("st_b3",  4'b0100, 1'b0, 4'b0100, 1'b1);
        cyc("st_end", 4'b0000, 1'b0, 4'b0000, 1'b0);
`else
        cyc("st_gap0", 4'b0100, 1'b0, 4'b0000, 1'b0);
        cyc("st_b0",   4'b0100, 1'b0, 4'b0100, 1'b1);
        cyc("st_gap1", 4'b0100, 1'b0, 4'b0000, 1'b0);
        cyc("st_b1",   4'b0100, 1'b0, 4'b0100, 1'b1);
        cyc("st_gap2", 4'b0100, 1'b0, 4'b0000, 1'b0);
        for (int i = 0; i < 3; i++) cyc("st_full", 4'b0100, 1'b1, 4'b0100, 1'b0);
        cyc("st_b2",   4'b0100, 1'b0, 4'b0100, 1'b1);
        cyc("st_gap3", 4'b0100, 1'b0, 4'b0000, 1'b0);
        cyc("st_b3",   4'b0100, 1'b0, 4'b0100, 1'b1);
        cyc("st_end",  4'b0000, 1'b0, 4'b0000, 1'b0);
`endif

        // owner 1 drops req after one beat while requester 3 waits
`ifdef FIFO_ARB_BURST_EN
        cyc("dr_gap",  4'b0010, 1'b0, 4'b0000, 1'b0);
        cyc("dr_b0",   4'b1010, 1'b0, 4'b0010, 1'b1);
        cyc("dr_rel",  4'b1000, 1'b0, 4'b0010, 1'b0);
        cyc("dr_gap2", 4'b1000, 1'b0, 4'b0000, 1'b0);
        cyc("dr_b3",   4'b1000, 1'b0, 4'b1000, 1'b1);
        cyc("dr_rel3", 4'b0000, 1'b0, 4'b1000, 1'b0);
`else
        cyc("dr_gap",  4'b0010, 1'b0, 4'b0000, 1'b0);
        cyc("dr_b0",   4'b1010, 1'b0, 4'b0010, 1'b1);
        cyc("dr_gap2", 4'b1000, 1'b0, 4'b0000, 1'b0);
        cyc("dr_b3",   4'b1000, 1'b0, 4'b1000, 1'b1);
        cyc("dr_end",  4'b0000, 1'b0, 4'b0000, 1'b0);
`endif

        // reset asserted while granted: no write that cycle, grant cleared after the edge
        cyc("rs_gap", 4'b0001, 1'b0, 4'b0000, 1'b0);
        rst = 1'b1;
        cyc("rs_hit", 4'b0001, 1'b0, 4'b0001, 1'b0);
        rst = 1'b0;
        cyc("rs_clr", 4'b0001, 1'b0, 4'b0000, 1'b0);
        cyc("rs_b0",  4'b0001, 1'b0, 4'b0001, 1'b1);
`ifdef FIFO_ARB_BURST_EN
        cyc("rs_rel", 4'b0000, 1'b0, 4'b0001, 1'b0);
`else
        cyc("rs_end", 4'b0000, 1'b0, 4'b0000, 1'b0);
`endif

        // fresh reset, then requesters 0 and 2 alternate
        rst = 1'b1;
        cyc("alt_rst", 4'b0000, 1'b0, 4'b0000, 1'b0);
        rst = 1'b0;
        for (int o = 0; o < 4; o++) begin
            cyc("alt_gap", 4'b0101, 1'b0, 4'b0000, 1'b0);
            for (int unsigned b = 0; b < BL; b++)
                cyc("alt_beat", 4'b0101, 1'b0, 4'(1 << order2[o]), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
